// File: rtl/code2421_bcd_decoder.sv
// 2421-code to packed 8421 BCD word assembler with valid/ready on both sides.
// Digits shift in at bits [3:0]; a word closes on in_last or when DIGITS digits are held.
module code2421_bcd_decoder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_code,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [3:0]            out_count,
  output logic                  out_err
);

  localparam logic [3:0] DIGITS_C = 4'(DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [4*DIGITS-1:0] acc_r, acc_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                err_r, err_s;
  logic [4*DIGITS-1:0] bcd_r, bcd_s;
  logic [3:0]          count_r, count_s;
  logic                oerr_r, oerr_s;

  logic [4:0]          dec_s;
  logic [4*DIGITS-1:0] digit_ext_s;
  logic [4*DIGITS-1:0] shifted_s;
  logic [3:0]          cnt_inc_s;
  logic                err_inc_s;

  // Returns {invalid, digit}; the six unused codes decode to 0 and flag invalid.
  function automatic logic [4:0] decode_2421(input logic [3:0] code);
    logic [4:0] res;
    if (code <= 4'd4) begin
      res = {1'b0, code};
    end else if (code >= 4'd11) begin
      res = {1'b0, code - 4'd6};
    end else begin
      res = {1'b1, 4'd0};
    end
    return res;
  endfunction

  // Digit decode and the candidate accumulator update for this cycle.
  always_comb begin
    dec_s          = decode_2421(in_code);
    digit_ext_s    = '0;
    digit_ext_s[3:0] = dec_s[3:0];
    shifted_s      = (acc_r << 3'd4) | digit_ext_s;
    cnt_inc_s      = cnt_r + 4'd1;
    err_inc_s      = err_r | dec_s[4];
  end

  // Next-state and next-data logic.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    bcd_s   = bcd_r;
    count_s = count_r;
    oerr_s  = oerr_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (in_valid) begin
          if (in_last || (cnt_inc_s == DIGITS_C)) begin
            state_s = HOLD;
            bcd_s   = shifted_s;
            count_s = cnt_inc_s;
            oerr_s  = err_inc_s;
            acc_s   = '0;
            cnt_s   = 4'd0;
            err_s   = 1'b0;
          end else begin
            state_s = ACCUM;
            acc_s   = shifted_s;
            cnt_s   = cnt_inc_s;
            err_s   = err_inc_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
          bcd_s   = '0;
          count_s = 4'd0;
          oerr_s  = 1'b0;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = '0;
        cnt_s   = 4'd0;
        err_s   = 1'b0;
        bcd_s   = '0;
        count_s = 4'd0;
        oerr_s  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Accumulator and held-word registers; held word is zero outside HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= '0;
      cnt_r   <= 4'd0;
      err_r   <= 1'b0;
      bcd_r   <= '0;
      count_r <= 4'd0;
      oerr_r  <= 1'b0;
    end else begin
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      bcd_r   <= bcd_s;
      count_r <= count_s;
      oerr_r  <= oerr_s;
    end
  end

  assign in_ready  = (state_r != HOLD);
  assign out_valid = (state_r == HOLD);
  assign out_bcd   = bcd_r;
  assign out_count = count_r;
  assign out_err   = oerr_r;

endmodule

// File: tb/tb_code2421_bcd_decoder.sv
// Directed bench for code2421_bcd_decoder (DIGITS=4) with hand-computed expectations.
module tb_code2421_bcd_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_count;
  logic        out_err;

  int checks;
  int failures;

  code2421_bcd_decoder #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_count (out_count),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] code, input logic last);
    in_valid = 1'b1;
    in_code  = code;
    in_last  = last;
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [15:0] bcd, input logic [3:0] cnt,
                          input logic err);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_bcd"},   {16'd0, out_bcd}, {16'd0, bcd});
    chk({tag, "_count"}, {28'd0, out_count}, {28'd0, cnt});
    chk({tag, "_err"},   {31'd0, out_err}, {31'd0, err});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_bcd"},   {16'd0, out_bcd}, 32'd0);
    chk({tag, "_count"}, {28'd0, out_count}, 32'd0);
    chk({tag, "_err"},   {31'd0, out_err}, 32'd0);
  endtask

  logic [3:0] exp_dig [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0,
                               4'd0, 4'd0, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  logic       exp_err [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_idle("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_idle("after_reset");

    // Full word: 1,5,9,4 closes on the fourth digit
    send(4'b0001, 1'b0);
    send(4'b1011, 1'b0);
    send(4'b1111, 1'b0);
    chk("full_not_yet_valid", {31'd0, out_valid}, 32'd0);
    send(4'b0100, 1'b0);
    chk_word("full", 16'h1594, 4'd4, 1'b0);
    step();
    chk_idle("full_popped");

    // Short word: 8, 3 with in_last
    send(4'b1110, 1'b0);
    send(4'b0011, 1'b1);
    chk_word("short", 16'h0083, 4'd2, 1'b0);
    step();

    // Invalid code, then a clean word
    send(4'b0010, 1'b0);
    send(4'b0111, 1'b1);
    chk_word("invalid", 16'h0020, 4'd2, 1'b1);
    step();
    send(4'b1111, 1'b1);
    chk_word("after_invalid", 16'h0009, 4'd1, 1'b0);
    step();

    // Backpressure in HOLD with in_valid asserted
    out_ready = 1'b0;
    send(4'b0001, 1'b1);
    in_valid = 1'b1;
    in_code  = 4'b0100;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_word("backpressure", 16'h0001, 4'd1, 1'b0);
      step();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    chk_idle("bp_released");
    send(4'b0011, 1'b1);
    chk_word("bp_next", 16'h0003, 4'd1, 1'b0);
    step();

    // Every code as a single-digit word
    for (int c = 0; c < 16; c++) begin
      send(4'(c), 1'b1);
      chk_word("decode", {12'd0, exp_dig[c]}, 4'd1, exp_err[c]);
      step();
    end

    // Reset mid-word discards the partial word
    send(4'b1100, 1'b0);
    send(4'b1101, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    step();
    rst_n = 1'b1;
    step();
    send(4'b0001, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b0011, 1'b0);
    send(4'b0100, 1'b0);
    chk_word("post_reset", 16'h1234, 4'd4, 1'b0);
    step();
    chk_idle("post_reset_popped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code2421_bcd_decoder.md
CODE2421_BCD_DECODER -- requirements
Module: code2421_bcd_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of BCD digits packed per output word; legal range 1..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_code/in_last are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a digit this cycle.
REQ-006 SHALL have port in_code, input, 4 bits: one 2421-coded decimal digit, bit 3 = weight-2 MSB.
REQ-007 SHALL have port in_last, input, 1 bit: the digit is the final digit of the current word.
REQ-008 SHALL have port out_valid, output, 1 bit: out_bcd/out_count/out_err hold a completed word.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-010 SHALL have port out_bcd, output, 4*DIGITS bits: packed 8421 BCD; the most recent digit is in bits [3:0].
REQ-011 SHALL have port out_count, output, 4 bits: number of digits in the word, 1..DIGITS.
REQ-012 SHALL have port out_err, output, 1 bit: at least one digit in the word was an invalid 2421 code.

Function
REQ-013 SHALL implement states IDLE (no digits held), ACCUM (1..DIGITS-1 digits held) and HOLD (word complete, out_valid=1).
REQ-014 SHALL define acceptance as in_valid & in_ready sampled on a rising clk edge.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD, with in_ready depending on state only.
REQ-016 SHALL decode valid codes 0000..0100 to the same value and codes 1011..1111 to the code minus 6 (giving 5..9).
REQ-017 SHALL treat codes 0101..1010 as invalid: store digit 0000 and set the word's sticky error bit.
REQ-018 SHALL, on each acceptance, shift the accumulator left 4 bits, insert the decoded digit into bits [3:0] and increment the digit count.
REQ-019 SHALL transition IDLE/ACCUM -> HOLD on an acceptance where in_last=1 or the count reaches DIGITS.
REQ-020 SHALL transition IDLE -> ACCUM, or ACCUM -> ACCUM, on any other acceptance.
REQ-021 SHALL assert out_valid on the cycle after the completing acceptance (latency of one clk).
REQ-022 SHALL hold out_bcd, out_count and out_err stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on out_valid & out_ready, go HOLD -> IDLE; the accumulator, count and error are cleared, and in_ready=1 on the next cycle.
REQ-024 SHALL keep unused upper nibbles of a short word (count < DIGITS) at 0000.
REQ-025 SHALL drive out_bcd, out_count and out_err to 0 whenever out_valid=0.
REQ-026 SHALL have no state change when in_valid=1 and in_ready=0.
REQ-027 SHALL not treat in_valid, in_code or in_last as meaningful while in_ready=0.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE, and clear the accumulator, count and error.
REQ-029 SHALL drive in_ready=1 and out_valid=0 while rst_n=0, with out_bcd, out_count and out_err all 0.
REQ-030 SHALL discard a partial or held word when rst_n is asserted mid-operation; the first acceptance after release starts a new word.

Verification
REQ-031 Full word: codes 0001, 1011, 1111, 0100 accepted back-to-back with out_ready=1 -> out_bcd=16'h1594, out_count=4, out_err=0, out_valid one cycle after the 4th acceptance.
REQ-032 Short word: 1110 then 0011 with in_last=1 -> out_bcd=16'h0083, out_count=2, out_err=0.
REQ-033 Invalid code: 0010, 0111 (in_last=1) -> out_bcd=16'h0020, out_count=2, out_err=1; the next word has out_err=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, no digit absorbed; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 Exhaustive decode: all 16 codes, each sent as a single-digit word with in_last=1 -> the 10 valid codes map to 0..9 with out_err=0; the 6 invalid codes give 0 with out_err=1.
REQ-036 Reset mid-word: 2 digits accepted, then rst_n low for 1 cycle -> out_valid=0, in_ready=1; the next 4 digits form a clean word with out_count=4.
